// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch sequencer. Issues credit-limited imem requests,
// buffers responses in a DEPTH-entry FIFO toward decode and discards stale responses after a flush.
module fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] flush_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_instr,
   input  logic             id_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] stale_q, stale_d;

   logic [WIDTH-1:0] tag_q [DEPTH];
   logic [WIDTH-1:0] tag_d [DEPTH];
   logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
   logic [PTR_W-1:0] tag_rd_q, tag_rd_d;

   logic [WIDTH-1:0] fifo_pc_q [DEPTH];
   logic [WIDTH-1:0] fifo_pc_d [DEPTH];
   logic [WIDTH-1:0] fifo_instr_q [DEPTH];
   logic [WIDTH-1:0] fifo_instr_d [DEPTH];
   logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
   logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

   logic [CNT_W:0]   credit_used;
   logic             fifo_empty;
   logic             fire;
   logic             push;
   logic             pop;

   // A credit covers a request from grant until its instruction leaves the FIFO.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
   assign imem_req    = (state_q == RUN) && (credit_used < {1'b0, DEPTH_C});
   assign imem_addr   = fetch_pc_q;
   assign fire        = imem_req && imem_gnt;

   assign fifo_empty  = (fifo_cnt_q == '0);
   assign if_valid    = !fifo_empty && !flush;
   assign if_pc       = fifo_empty ? '0 : fifo_pc_q[fifo_rd_q];
   assign if_instr    = fifo_empty ? '0 : fifo_instr_q[fifo_rd_q];
   assign pop         = if_valid && id_ready;
   assign push        = imem_rvalid && (stale_q == '0) && !flush;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(imem_rvalid);
      stale_d       = stale_q;
      tag_d         = tag_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_instr_d  = fifo_instr_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_rd_d     = fifo_rd_q;
      fifo_cnt_d    = fifo_cnt_q;

      if (fire) begin
         tag_d[tag_wr_q] = fetch_pc_q;
         tag_wr_d        = tag_wr_q + PTR_W'(1);
         fetch_pc_d      = fetch_pc_q + WIDTH'(4);
      end

      // Every response retires its tag, whether it is delivered or dropped.
      if (imem_rvalid) begin
         tag_rd_d = tag_rd_q + PTR_W'(1);
         if (stale_q != '0) begin
            stale_d = stale_q - CNT_W'(1);
         end
      end

      if (flush) begin
         fifo_wr_d  = '0;
         fifo_rd_d  = '0;
         fifo_cnt_d = '0;
         fetch_pc_d = flush_pc;
         if (state_q != BOOT) begin
            stale_d = outstanding_d;
         end
      end else begin
         if (push) begin
            fifo_pc_d[fifo_wr_q]    = tag_q[tag_rd_q];
            fifo_instr_d[fifo_wr_q] = imem_rdata;
            fifo_wr_d               = fifo_wr_q + PTR_W'(1);
         end
         if (pop) begin
            fifo_rd_d = fifo_rd_q + PTR_W'(1);
         end
         fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (flush && (stale_d != '0)) state_d = DRAIN;
         DRAIN:   if (stale_d == '0) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         stale_q       <= '0;
         tag_q         <= '{default: '0};
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         fifo_pc_q     <= '{default: '0};
         fifo_instr_q  <= '{default: '0};
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         fifo_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         tag_q         <= tag_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         fifo_pc_q     <= fifo_pc_d;
         fifo_instr_q  <= fifo_instr_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_cnt_q    <= fifo_cnt_d;
      end
   end

`ifndef SYNTHESIS
   rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (outstanding_q != '0));
   no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      push |-> (fifo_cnt_q != DEPTH_C));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, hand sequences and randomized traffic for fetch_ctrl,
// checked against a queue-based reference of in-flight requests and buffered instructions.
module tb_fetch_ctrl;

   localparam int          WIDTH    = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        id_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .id_ready   (id_ready)
   );

   // Reference: each request in flight carries a stale mark; decode sees a queue of {pc, instr}.
   typedef struct { logic [31:0] pc; logic stale; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

   flight_t     inflight[$];
   entry_t      buffered[$];
   logic        m_boot = 1'b1;
   logic [31:0] m_pc = RESET_PC;

   typedef struct {
      logic g, rv; logic [31:0] rdata; logic rdy, fl; logic [31:0] fpc;
      logic req; logic [31:0] addr; logic valid; logic [31:0] pc, instr;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic int stale_count();
      int n = 0;
      foreach (inflight[i]) if (inflight[i].stale) n++;
      return n;
   endfunction

   function automatic logic model_req();
      return !m_boot && (stale_count() == 0) && (inflight.size() + buffered.size() < DEPTH);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel();
      logic exp_req;
      logic has;
      exp_req = model_req();
      has     = buffered.size() > 0;
      checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("if_valid", 32'(if_valid), 32'(has && !flush));
      checkOutput("if_pc", if_pc, has ? buffered[0].pc : 32'h0);
      checkOutput("if_instr", if_instr, has ? buffered[0].instr : 32'h0);
   endtask

   task automatic modelUpdate();
      logic    fire;
      logic    pop;
      flight_t f;
      fire = model_req() && imem_gnt;
      pop  = (buffered.size() > 0) && !flush && id_ready;
      if (pop) void'(buffered.pop_front());
      if (imem_rvalid) begin
         f = inflight.pop_front();
         if (!f.stale && !flush) buffered.push_back('{f.pc, instr_of(f.pc)});
      end
      if (fire) begin
         inflight.push_back('{m_pc, 1'b0});
         m_pc = m_pc + 32'd4;
      end
      if (flush) begin
         buffered.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         m_pc = flush_pc;
      end
      m_boot = 1'b0;
   endtask

   // One cycle: drive at the falling edge, compare against the reference, then advance it.
   task automatic applyStimulus(input logic g, input logic rv, input logic rdy,
                                input logic fl, input logic [31:0] fpc);
      @(negedge clk);
      imem_gnt    = g;
      imem_rvalid = rv && (inflight.size() > 0);
      imem_rdata  = imem_rvalid ? instr_of(inflight[0].pc) : $urandom;
      id_ready    = rdy;
      flush       = fl;
      flush_pc    = fpc;
      #1;
      checkModel();
      modelUpdate();
   endtask

   task automatic resetDut();
      @(posedge clk);
      #2;
      rst         = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      flush       = 1'b0;
      id_ready    = 1'b0;
      #1;
      checkOutput("rst_req", 32'(imem_req), 32'h0);
      checkOutput("rst_addr", imem_addr, RESET_PC);
      checkOutput("rst_valid", 32'(if_valid), 32'h0);
      checkOutput("rst_pc", if_pc, 32'h0);
      checkOutput("rst_instr", if_instr, 32'h0);
      inflight.delete();
      buffered.delete();
      m_boot = 1'b1;
      m_pc   = RESET_PC;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic vec(input logic g, input logic rv, input logic [31:0] rdata, input logic rdy,
                      input logic fl, input logic [31:0] fpc, input logic req,
                      input logic [31:0] addr, input logic valid, input logic [31:0] pc,
                      input logic [31:0] instr);
      vecs.push_back('{g, rv, rdata, rdy, fl, fpc, req, addr, valid, pc, instr});
   endtask

   task automatic waitValid(input string name, input logic [31:0] exp_pc);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         if (if_valid) found = 1;
      end
      checkOutput({name, "_seen"}, 32'(found), 32'h1);
      checkOutput({name, "_pc"}, if_pc, exp_pc);
   endtask

   initial begin
      // Row 0 is the BOOT cycle; 1-cycle responses, then a decode stall, gnt gaps and a flush.
      vec(1, 0, 0,                1, 0, 0,        0, 32'h0,   0, 32'h0,   0);
      vec(1, 0, 0,                1, 0, 0,        1, 32'h0,   0, 32'h0,   0);
      vec(1, 1, instr_of(32'h0),  1, 0, 0,        1, 32'h4,   0, 32'h0,   0);
      vec(1, 1, instr_of(32'h4),  1, 0, 0,        0, 32'h8,   1, 32'h0,   instr_of(32'h0));
      vec(1, 0, 0,                1, 0, 0,        1, 32'h8,   1, 32'h4,   instr_of(32'h4));
      vec(1, 1, instr_of(32'h8),  1, 0, 0,        1, 32'hC,   0, 32'h0,   0);
      vec(1, 1, instr_of(32'hC),  0, 0, 0,        0, 32'h10,  1, 32'h8,   instr_of(32'h8));
      vec(1, 0, 0,                0, 0, 0,        0, 32'h10,  1, 32'h8,   instr_of(32'h8));
      vec(1, 0, 0,                0, 0, 0,        0, 32'h10,  1, 32'h8,   instr_of(32'h8));
      vec(1, 0, 0,                1, 0, 0,        0, 32'h10,  1, 32'h8,   instr_of(32'h8));
      vec(1, 0, 0,                0, 0, 0,        1, 32'h10,  1, 32'hC,   instr_of(32'hC));
      vec(1, 0, 0,                0, 0, 0,        0, 32'h14,  1, 32'hC,   instr_of(32'hC));
      vec(0, 1, instr_of(32'h10), 0, 0, 0,        0, 32'h14,  1, 32'hC,   instr_of(32'hC));
      vec(0, 0, 0,                1, 0, 0,        0, 32'h14,  1, 32'hC,   instr_of(32'hC));
      vec(0, 0, 0,                1, 0, 0,        1, 32'h14,  1, 32'h10,  instr_of(32'h10));
      vec(0, 0, 0,                1, 0, 0,        1, 32'h14,  0, 32'h0,   0);
      vec(1, 0, 0,                1, 0, 0,        1, 32'h14,  0, 32'h0,   0);
      vec(0, 1, instr_of(32'h14), 1, 0, 0,        1, 32'h18,  0, 32'h0,   0);
      vec(0, 0, 0,                1, 1, 32'h100,  1, 32'h18,  0, 32'h14,  instr_of(32'h14));
      vec(1, 0, 0,                1, 0, 0,        1, 32'h100, 0, 32'h0,   0);
      vec(1, 1, instr_of(32'h100),1, 0, 0,        1, 32'h104, 0, 32'h0,   0);
      vec(0, 1, instr_of(32'h104),1, 0, 0,        0, 32'h108, 1, 32'h100, instr_of(32'h100));
      vec(0, 0, 0,                1, 0, 0,        1, 32'h108, 1, 32'h104, instr_of(32'h104));
      vec(0, 0, 0,                1, 0, 0,        1, 32'h108, 0, 32'h0,   0);

      $display("[TB] vector table");
      resetDut();
      foreach (vecs[k]) begin
         @(negedge clk);
         imem_gnt    = vecs[k].g;
         imem_rvalid = vecs[k].rv;
         imem_rdata  = vecs[k].rdata;
         id_ready    = vecs[k].rdy;
         flush       = vecs[k].fl;
         flush_pc    = vecs[k].fpc;
         #1;
         checkOutput($sformatf("vec%0d_req", k), 32'(imem_req), 32'(vecs[k].req));
         checkOutput($sformatf("vec%0d_addr", k), imem_addr, vecs[k].addr);
         checkOutput($sformatf("vec%0d_valid", k), 32'(if_valid), 32'(vecs[k].valid));
         checkOutput($sformatf("vec%0d_pc", k), if_pc, vecs[k].pc);
         checkOutput($sformatf("vec%0d_instr", k), if_instr, vecs[k].instr);
      end

      $display("[TB] flush with two requests in flight");
      resetDut();
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 32'h100);
      waitValid("t3_first", 32'h100);
      applyStimulus(0, 1, 1, 0, 0);
      waitValid("t3_second", 32'h104);

      $display("[TB] flush coincident with grant and response");
      resetDut();
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h200);
      checkOutput("t4_flush_req", 32'(imem_req), 32'h1);
      checkOutput("t4_flush_addr", imem_addr, 32'h10);
      begin
         bit seen = 0;
         for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1, 1, 1, 0, 0);
            if (imem_req) seen = 1;
         end
         checkOutput("t4_req_seen", 32'(seen), 32'h1);
         checkOutput("t4_next_addr", imem_addr, 32'h200);
      end
      waitValid("t4_first", 32'h200);

      $display("[TB] grant held low");
      resetDut();
      applyStimulus(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         checkOutput("t5_hold_addr", imem_addr, 32'h0);
      end
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t5_advanced_addr", imem_addr, 32'h4);

      $display("[TB] address wrap and mid-stream reset");
      resetDut();
      applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFC);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("t6_wrap_first", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("t6_wrap_second", imem_addr, 32'h0);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      resetDut();
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("t6_restart_addr", imem_addr, RESET_PC);

      $display("[TB] randomized traffic");
      resetDut();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            resetDut();
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          $urandom & 32'hFFFF_FFFC);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
